// File: rtl/ctrlpid_qenc_v.sv
// ctrlpid_qenc_v: per-channel quadrature decoder, position counter and setpoint store producing the saturated PID error
module ctrlpid_qenc_v #(
    parameter int aw = 1,
    parameter int an = 2**aw,
    parameter int ew = 24,
    parameter int pw = 32,
    parameter int fl = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [an-1:0] enc_a,
    input  logic [an-1:0] enc_b,
    input  logic [aw-1:0] a,
    input  logic [pw-1:0] setpoint,
    input  logic          sp_we,
    input  logic          pos_clr,
    input  logic          fault_clr,
    output logic [ew-1:0] error,
    output logic [pw-1:0] position,
    output logic [an-1:0] fault
);
    localparam int cw = $clog2(fl + 1);
    logic [an-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [an-1:0][pw-1:0] pos_w, sp_w;
    logic [an-1:0] fault_w;
    logic [pw:0] diff;
    logic [ew-1:0] error_q, error_d;
    logic [pw-1:0] position_q;
    // two-flop synchronizers on the raw encoder phases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_s1_q <= '0;
            a_s2_q <= '0;
            b_s1_q <= '0;
            b_s2_q <= '0;
        end else begin
            a_s1_q <= enc_a;
            a_s2_q <= a_s1_q;
            b_s1_q <= enc_b;
            b_s2_q <= b_s1_q;
        end
    end
    for (genvar g = 0; g < an; g++) begin : g_ch
        logic [1:0] s, cand_q, filt_q, qs_q, i_old, i_new, dlt;
        logic [cw-1:0] cnt_q;
        logic filt_v_q, init_q, hit, chg, fwd, rev, bad;
        logic [pw-1:0] pos_q, pos_d, sp_q, sp_d;
        logic fault_q, fault_d;
        assign s = {a_s2_q[g], b_s2_q[g]};
        // glitch filter: synchronized AB must match the candidate for fl consecutive clocks
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cand_q <= '0;
                cnt_q <= '0;
                filt_q <= '0;
                filt_v_q <= 1'b0;
            end else if (s != cand_q) begin
                cand_q <= s;
                cnt_q <= cw'(1);
            end else if (cnt_q != cw'(fl)) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == cw'(fl - 1)) begin
                    filt_q <= cand_q;
                    filt_v_q <= 1'b1;
                end
            end
        end
        // gray code to quadrant index; the index difference gives direction, two steps is illegal
        assign i_old = {qs_q[1], qs_q[1] ^ qs_q[0]};
        assign i_new = {filt_q[1], filt_q[1] ^ filt_q[0]};
        assign dlt = i_new - i_old;
        assign chg = filt_v_q & init_q & (filt_q != qs_q);
        assign fwd = chg & (dlt == 2'd1);
        assign rev = chg & (dlt == 2'd3);
        assign bad = chg & (dlt == 2'd2);
        assign hit = a == aw'(g);
        assign pos_d = (pos_clr && hit) ? '0 : fwd ? pos_q + 1'b1 : rev ? pos_q - 1'b1 : pos_q;
        assign sp_d = (sp_we && hit) ? setpoint : sp_q;
        assign fault_d = bad | (fault_q & ~fault_clr);
        // decoder state, position, setpoint and sticky fault; the first settled value only arms the decoder
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                qs_q <= '0;
                init_q <= 1'b0;
                pos_q <= '0;
                sp_q <= '0;
                fault_q <= 1'b0;
            end else begin
                if (filt_v_q) begin
                    qs_q <= filt_q;
                    init_q <= 1'b1;
                end
                pos_q <= pos_d;
                sp_q <= sp_d;
                fault_q <= fault_d;
            end
        end
        assign pos_w[g] = pos_q;
        assign sp_w[g] = sp_q;
        assign fault_w[g] = fault_q;
    end
    assign diff = {sp_w[a][pw-1], sp_w[a]} - {pos_w[a][pw-1], pos_w[a]};
    assign error_d = (&diff[pw:ew-1] || ~|diff[pw:ew-1]) ? diff[ew-1:0] :
                     diff[pw] ? {1'b1, {(ew-1){1'b0}}} : {1'b0, {(ew-1){1'b1}}};
    // registered readout of the selected channel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= '0;
            position_q <= '0;
        end else begin
            error_q <= error_d;
            position_q <= pos_w[a];
        end
    end
    assign error = error_q;
    assign position = position_q;
    assign fault = fault_w;
endmodule

// File: tb/tb_ctrlpid_qenc_v.sv
// tb_ctrlpid_qenc_v: directed scoreboard bench for the quadrature front end
module tb_ctrlpid_qenc_v;
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] enc_a = '0, enc_b = '0;
    logic a = 1'b0;
    logic [31:0] setpoint = '0;
    logic sp_we = 1'b0, pos_clr = 1'b0, fault_clr = 1'b0;
    logic [23:0] error;
    logic [31:0] position;
    logic [1:0] fault;
    typedef struct { string tag; logic [63:0] v; } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;

    ctrlpid_qenc_v dut (.clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .a(a),
        .setpoint(setpoint), .sp_we(sp_we), .pos_clr(pos_clr), .fault_clr(fault_clr),
        .error(error), .position(position), .fault(fault));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
        end
    endtask

    task automatic set_ab(input int ch, input logic [1:0] v, input int hold);
        enc_a[ch] = v[1];
        enc_b[ch] = v[0];
        tick(hold);
    endtask

    task automatic write_sp(input logic ch, input logic [31:0] v);
        a = ch;
        setpoint = v;
        sp_we = 1'b1;
        tick(1);
        sp_we = 1'b0;
    endtask

    initial begin
        logic [1:0] fseq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [1:0] rseq [3] = '{2'b10, 2'b11, 2'b01};
        // reset state
        tick(2);
        push("rst_error", 64'h0); pop_chk({40'b0, error});
        push("rst_position", 64'h0); pop_chk({32'b0, position});
        push("rst_fault", 64'h0); pop_chk({62'b0, fault});
        reset = 1'b0;
        tick(10);
        // forward count on ch0
        push("t1_position", 64'd8);
        push("t1_error", 64'hFFFFF8);
        push("t1_fault", 64'h0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) set_ab(0, fseq[i], 8);
        tick(10);
        pop_chk({32'b0, position});
        pop_chk({40'b0, error});
        pop_chk({62'b0, fault});
        // reverse count on ch1 with setpoint 100
        write_sp(1'b1, 32'd100);
        push("t2_position_ch1", 64'hFFFFFFFD);
        push("t2_error_ch1", 64'd103);
        for (int i = 0; i < 3; i++) set_ab(1, rseq[i], 8);
        tick(10);
        pop_chk({32'b0, position});
        pop_chk({40'b0, error});
        a = 1'b0;
        push("t2_position_ch0", 64'd8);
        tick(2);
        pop_chk({32'b0, position});
        // short glitch on ch0 phase A is filtered out
        push("t3_glitch_position", 64'd8);
        push("t3_glitch_fault", 64'h0);
        enc_a[0] = 1'b1;
        tick(2);
        enc_a[0] = 1'b0;
        tick(12);
        pop_chk({32'b0, position});
        pop_chk({62'b0, fault});
        // illegal jump 00->11
        push("t3_fault_set", 64'h1);
        push("t3_fault_position", 64'd8);
        set_ab(0, 2'b11, 12);
        pop_chk({62'b0, fault});
        pop_chk({32'b0, position});
        push("t3_fault_clr", 64'h0);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        pop_chk({62'b0, fault});
        // error saturation and its exact boundaries, sp_we together with pos_clr
        push("t4_clr_position", 64'h0);
        push("t4_sat_pos", 64'h7FFFFF);
        a = 1'b0;
        pos_clr = 1'b1;
        write_sp(1'b0, 32'h0090_0000);
        pos_clr = 1'b0;
        tick(2);
        pop_chk({32'b0, position});
        pop_chk({40'b0, error});
        push("t4_sat_neg", 64'h800000);
        write_sp(1'b0, 32'hFF00_0000);
        tick(2);
        pop_chk({40'b0, error});
        push("t4_edge_pos", 64'h7FFFFF);
        write_sp(1'b0, 32'h007F_FFFF);
        tick(2);
        pop_chk({40'b0, error});
        push("t4_edge_neg", 64'h800000);
        write_sp(1'b0, 32'hFF80_0000);
        tick(2);
        pop_chk({40'b0, error});
        push("t4_over_pos", 64'h7FFFFF);
        write_sp(1'b0, 32'h0080_0000);
        tick(2);
        pop_chk({40'b0, error});
        // 0 - 1 wraps to all ones; raw-to-output latency 2 + fl + 1 + readout register
        write_sp(1'b0, 32'h7FFF_FFFF);
        push("t5_latency_hold", 64'h0);
        push("t5_wrap", 64'hFFFFFFFF);
        push("t5_wrap_error", 64'h7FFFFF);
        set_ab(0, 2'b01, 7);
        pop_chk({32'b0, position});
        tick(1);
        pop_chk({32'b0, position});
        tick(1);
        pop_chk({40'b0, error});
        tick(6);
        // pos_clr on the very clock the next count lands
        push("t5_clr_wins", 64'h0);
        set_ab(0, 2'b00, 6);
        pos_clr = 1'b1;
        tick(1);
        pos_clr = 1'b0;
        tick(2);
        pop_chk({32'b0, position});
        tick(6);
        // asynchronous reset mid-sequence
        push("t6_pre_reset", 64'd2);
        set_ab(0, 2'b01, 8);
        set_ab(0, 2'b11, 10);
        pop_chk({32'b0, position});
        push("t6_async_position", 64'h0);
        push("t6_async_error", 64'h0);
        #3 reset = 1'b1;
        #1;
        pop_chk({32'b0, position});
        pop_chk({40'b0, error});
        tick(2);
        reset = 1'b0;
        push("t6_init_no_count", 64'h0);
        tick(14);
        pop_chk({32'b0, position});
        push("t6_resume", 64'd1);
        push("t6_resume_error", 64'hFFFFFF);
        set_ab(0, 2'b10, 10);
        pop_chk({32'b0, position});
        pop_chk({40'b0, error});
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ctrlpid_qenc_v.md
Name: ctrlpid_qenc_v

Overview:
- Feedback front end for the multiplexed PID controller: per-channel quadrature encoder decoder, position counter and setpoint store.
- Produces the signed, saturated error (setpoint - position) that feeds the PID error input.
- Uses the same channel address `a` as the PID, so both blocks index the same motor.
- Runs on the fast system clock; the PID samples `error` on its own slower clock.

Parameters:
- aw, 1: channel address width.
- an, 2^aw: number of encoder channels.
- ew, 24: error output width (signed).
- pw, 32: position/setpoint width (signed), ew < pw.
- fl, 4: glitch-filter length; input must be stable fl consecutive clocks (fl >= 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enc_a  in  an  raw quadrature phase A per channel (asynchronous).
- enc_b  in  an  raw quadrature phase B per channel (asynchronous).
- a  in  aw  channel select for setpoint write, clear, and error/position readout.
- setpoint  in  pw  signed target position, written to channel a.
- sp_we  in  1  setpoint write strobe.
- pos_clr  in  1  clear position of channel a.
- fault_clr  in  1  clear all fault flags.
- error  out  ew  signed sat(setpoint[a] - position[a]).
- position  out  pw  signed position[a].
- fault  out  an  sticky illegal-transition flag per channel.

Behaviour:
- Reset (async, active-high):
  - All positions, setpoints, error, position and fault clear to 0.
  - Filters clear.
  - Per-channel init flag cleared.
- Synchronizer: each enc_a/enc_b passes through a 2-FF synchronizer.
- Glitch filter:
  - Per-channel counter; synchronized AB must equal the candidate value for fl consecutive clocks before the filtered AB updates.
  - Any mismatch reloads the candidate and restarts the count.
- Decoder state per channel: previous filtered AB (qs) and an init flag.
- First filtered value after reset: loads qs and sets init; no count.
- Transitions compare qs with the new filtered AB:
  - Forward 00->01->11->10->00: position +1.
  - Reverse 00->10->11->01->00: position -1.
  - Equal: no change.
  - Both bits changed (00<->11, 01<->10): illegal. No count, fault[ch] set; qs still updates.
- Latency: filtered edge to position update is 1 clock. Raw pin to position update is 2 (sync) + fl (filter) + 1 clocks.
- Position arithmetic:
  - pw-bit two's complement, wraps modulo 2^pw: 0x7FFFFFFF +1 -> 0x80000000; 0 -1 -> 0xFFFFFFFF.
  - No saturation on position.
- pos_clr: position[a] <= 0 on the next clock. If a count event on the same channel coincides, clear wins.
- sp_we: setpoint[a] <= setpoint on the next clock. sp_we and pos_clr in the same cycle both take effect.
- Channels count independently and simultaneously; writes affect only channel a.
- Error (registered, 1-clock latency from any change of a, setpoint[a] or position[a]):
  - diff = setpoint[a] - position[a], computed in pw+1 bits signed.
  - If diff > 2^(ew-1)-1: error = 0x7FFFFF.
  - If diff < -2^(ew-1): error = 0x800000.
  - Otherwise: error = diff[ew-1:0].
- position output: registered position[a], same 1-clock latency.
- fault_clr clears all flags. If fault_clr coincides with a new illegal transition, set wins.
- Reset mid-count: everything returns to reset values immediately. Counting resumes only after the next init load.

Test Plan:
1. Reset, hold AB=00 for 10 clks, then forward sequence 01,11,10,00 twice on ch0, each held 8 clks -> position=8, error=-8 (0xFFFFF8), fault=0.
2. On ch1, sp_we with a=1, setpoint=100, then 3 reverse steps -> position[1]=-3, error with a=1 = 103. Ch0 unchanged.
3. 2-clock glitch on A of ch0 (shorter than fl=4) -> no count. Jump AB 00->11 -> fault[0]=1, position unchanged. fault_clr -> fault[0]=0.
4. setpoint=0x00900000, position 0 -> error=0x7FFFFF. setpoint=0xFF000000 -> error=0x800000.
5. Preload position to 0x7FFFFFFF by counting from cleared state with setpoint=0x7FFFFFFF and checking wrap near the edge (force via pos_clr then -1 step) -> 0 -1 gives position 0xFFFFFFFF. pos_clr coincident with a count -> position 0.
6. Assert reset asynchronously mid-sequence -> outputs 0 the same cycle. The next valid edge after init load counts from 0.
